mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/riscv_defines.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 82 ++++++++
 tb/tb_mem_port_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared definitions for the core's memory-side blocks: arbiter state
// encoding, the reset-time instruction word and an address helper.
package riscv_defines;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        FETCH   = 2'd2,
        RELEASE = 2'd3
    } MemArbState_t;

    // addi x0, x0, 0 -- harmless word presented to decode before the first fetch
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Datapath-side and bus-side signals of the shared memory port.
// master = the arbiter, slave = the datapath/memory environment around it.
interface mem_port_arbiter_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_rd;
    logic [31:0] dmem_rdata;
    logic        halt;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        input  imem_addr, dmem_addr, dmem_wdata, dmem_wmask, dmem_rd,
        input  mem_rdata, mem_ready,
        output imem_rdata, dmem_rdata, halt,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        output imem_addr, dmem_addr, dmem_wdata, dmem_wmask, dmem_rd,
        output mem_rdata, mem_ready,
        input  imem_rdata, dmem_rdata, halt,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-bus arbiter: each instruction does an optional data access, then
// the next fetch, while the pipeline is frozen until a one-cycle RELEASE.
module mem_port_arbiter
    import riscv_defines::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic                  clk,
    input  logic                  resetn,
    mem_port_arbiter_if.master    bus
);

    MemArbState_t state;
    logic [31:0]  fetchAddr;
    logic [31:0]  dataAddr;
    logic [31:0]  dataWdata;
    logic [3:0]   dataWmask;
    logic         dataRd;
    logic [31:0]  imemRdata;
    logic [31:0]  dmemRdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            fetchAddr <= RESET_ADDR;
            dataAddr  <= '0;
            dataWdata <= '0;
            dataWmask <= '0;
            dataRd    <= 1'b0;
            imemRdata <= NOP_INSTR;
            dmemRdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fetchAddr <= bus.imem_addr;
                    dataAddr  <= bus.dmem_addr;
                    dataWdata <= bus.dmem_wdata;
                    dataWmask <= bus.dmem_wmask;
                    dataRd    <= bus.dmem_rd;
                    state     <= (bus.dmem_rd || (bus.dmem_wmask != 4'b0)) ? DATA : FETCH;
                end
                DATA: begin
                    if (bus.mem_ready) begin
                        // a store wins over a simultaneous load, so no read data is taken
                        if (dataRd && (dataWmask == 4'b0))
                            dmemRdata <= bus.mem_rdata;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        imemRdata <= bus.mem_rdata;
                        state     <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and halt are pure decodes of registered state and capture registers,
    // so they cannot move while a request waits for mem_ready.
    always_comb begin
        bus.halt      = (state != RELEASE);
        bus.mem_valid = (state == DATA) || (state == FETCH);
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (state == DATA) begin
            bus.mem_addr  = wordAlign(dataAddr);
            bus.mem_wdata = dataWdata;
            bus.mem_wstrb = dataWmask;
        end else if (state == FETCH) begin
            bus.mem_addr  = wordAlign(fetchAddr);
        end
    end

    assign bus.imem_rdata = imemRdata;
    assign bus.dmem_rdata = dmemRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, random instruction stream
// against an instruction-level model, and async reset in mid-transfer.
module tb_mem_port_arbiter;
    import riscv_defines::*;

    localparam logic [31:0] RST_ADDR = 32'h0000_0080;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.RESET_ADDR(RST_ADDR)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int nVec = 0;
    int nErr = 0;
    logic [31:0] modelDmem;

    typedef struct {
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rd;
        int          dDly;
        int          fDly;
        logic [31:0] dRsp;
        logic [31:0] fRsp;
        int          expCycles;
        logic [31:0] expImem;
        logic [31:0] expDmem;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the next IDLE negedge.
    task automatic runInstr(input vec_t v);
        int cycles, waitCnt, ph, dly;
        logic [31:0] rsp, eAddr, eWdata;
        logic [3:0] eStrb;
        bus.imem_addr  = v.iaddr;
        bus.dmem_addr  = v.daddr;
        bus.dmem_wdata = v.wdata;
        bus.dmem_wmask = v.wmask;
        bus.dmem_rd    = v.rd;
        bus.mem_ready  = 1'b1;          // must be ignored while mem_valid=0
        bus.mem_rdata  = $urandom;
        check("idle_halt", {31'b0, bus.halt}, 32'd1);
        check("idle_valid", {31'b0, bus.mem_valid}, 32'd0);
        ph      = (v.rd || v.wmask != 4'b0) ? 0 : 1;
        cycles  = 1;
        waitCnt = 0;
        forever begin
            @(negedge clk);
            cycles++;
            bus.imem_addr  = $urandom;
            bus.dmem_addr  = $urandom;
            bus.dmem_wdata = $urandom;
            bus.dmem_wmask = 4'($urandom);
            bus.dmem_rd    = 1'($urandom);
            if (cycles > 64) begin
                nVec++;
                nErr++;
                $display("FAIL timeout: no RELEASE after %0d cycles", cycles);
                break;
            end
            if (!bus.halt) begin
                check("rel_valid", {31'b0, bus.mem_valid}, 32'd0);
                check("rel_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
                check("rel_wdata", bus.mem_wdata, 32'd0);
                check("imem_rdata", bus.imem_rdata, v.expImem);
                check("dmem_rdata", bus.dmem_rdata, v.expDmem);
                check("cycles", cycles, v.expCycles);
                bus.mem_ready = 1'b1;
                bus.mem_rdata = $urandom;
                break;
            end
            eAddr  = (ph == 0) ? {v.daddr[31:2], 2'b00} : {v.iaddr[31:2], 2'b00};
            eWdata = (ph == 0) ? v.wdata : 32'd0;
            eStrb  = (ph == 0) ? v.wmask : 4'd0;
            check("bus_valid", {31'b0, bus.mem_valid}, 32'd1);
            check("bus_addr", bus.mem_addr, eAddr);
            check("bus_wdata", bus.mem_wdata, eWdata);
            check("bus_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, eStrb});
            dly = (ph == 0) ? v.dDly : v.fDly;
            rsp = (ph == 0) ? v.dRsp : v.fRsp;
            if (waitCnt == dly) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rsp;
                waitCnt = 0;
                ph++;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
                waitCnt++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        bit isData;
        // iaddr, daddr, wdata, wmask, rd, dDly, fDly, dRsp, fRsp, cycles, imem, dmem
        tbl[0] = '{32'h0000_0000, 32'h0, 32'h0, 4'b0000, 1'b0, 0, 0, 32'h0,
                   32'h0050_0093, 3, 32'h0050_0093, 32'h0};
        tbl[1] = '{32'h0000_0004, 32'h0000_1006, 32'h0, 4'b0000, 1'b1, 0, 0, 32'hCAFE_BABE,
                   32'h00A0_0113, 4, 32'h00A0_0113, 32'hCAFE_BABE};
        tbl[2] = '{32'h0000_0008, 32'h0000_2000, 32'h0000_BEEF, 4'b0011, 1'b0, 0, 0, 32'hDEAD_DEAD,
                   32'h00B0_0193, 4, 32'h00B0_0193, 32'hCAFE_BABE};
        tbl[3] = '{32'h0000_000C, 32'h0000_3008, 32'h0, 4'b0000, 1'b1, 3, 0, 32'h1234_5678,
                   32'h00C0_0213, 7, 32'h00C0_0213, 32'h1234_5678};
        tbl[4] = '{32'h0000_0012, 32'h0000_400B, 32'hA5A5_A5A5, 4'b1000, 1'b1, 0, 2, 32'hFFFF_FFFF,
                   32'h00D0_0293, 6, 32'h00D0_0293, 32'h1234_5678};

        bus.imem_addr = 32'h0; bus.dmem_addr = 32'h0; bus.dmem_wdata = 32'h0;
        bus.dmem_wmask = 4'h0; bus.dmem_rd = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check("rst_halt", {31'b0, bus.halt}, 32'd1);
        check("rst_valid", {31'b0, bus.mem_valid}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
        check("rst_imem", bus.imem_rdata, NOP_INSTR);
        check("rst_dmem", bus.dmem_rdata, 32'd0);
        resetn = 1'b1;

        foreach (tbl[i]) runInstr(tbl[i]);
        modelDmem = 32'h1234_5678;

        // random stream, expectations from instruction-level rules
        for (int n = 0; n < 40; n++) begin
            v.iaddr = $urandom;
            v.daddr = $urandom;
            v.wdata = $urandom;
            v.wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
            v.rd    = 1'($urandom);
            v.dDly  = $urandom_range(0, 3);
            v.fDly  = $urandom_range(0, 3);
            v.dRsp  = $urandom;
            v.fRsp  = $urandom;
            isData  = v.rd || (v.wmask != 4'b0);
            if (v.rd && v.wmask == 4'b0) modelDmem = v.dRsp;
            v.expCycles = 3 + v.fDly + (isData ? 1 + v.dDly : 0);
            v.expImem   = v.fRsp;
            v.expDmem   = modelDmem;
            runInstr(v);
        end

        // async reset in the middle of a stalled fetch
        bus.imem_addr = 32'h0000_0200; bus.dmem_rd = 1'b0; bus.dmem_wmask = 4'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("mid_valid", {31'b0, bus.mem_valid}, 32'd1);
        check("mid_addr", bus.mem_addr, 32'h0000_0200);
        #2 resetn = 1'b0;
        #1;
        check("arst_valid", {31'b0, bus.mem_valid}, 32'd0);
        check("arst_addr", bus.mem_addr, 32'd0);
        check("arst_halt", {31'b0, bus.halt}, 32'd1);
        check("arst_imem", bus.imem_rdata, NOP_INSTR);
        check("arst_dmem", bus.dmem_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        v = '{RST_ADDR, 32'h0, 32'h0, 4'b0000, 1'b0, 0, 1, 32'h0,
              32'h0010_0013, 4, 32'h0010_0013, 32'h0};
        runInstr(v);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
